// File: rtl/tm1638_ctrl.sv
// Write-only TM1638 controller: on start, latches 16 display bytes plus brightness/on settings
// and sends the data-command, address+data and display-control frames LSB first on STB/CLK/DIO.
module tm1638_ctrl #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic         clki,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] disp_data,
  input  logic [2:0]   bright,
  input  logic         disp_on,
  output logic         stb,
  output logic         sclk,
  output logic         dio,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_LO = 2'd1,
    BIT_HI = 2'd2,
    GAP    = 2'd3
  } state_e;

  localparam logic [16:0] PHASE_LAST = 17'(CLK_DIV - 1);
  localparam logic [16:0] GAP_LAST   = 17'(2 * CLK_DIV - 1);

  state_e         state_q, state_d;
  logic [15:0]    div_q, div_d;
  logic [2:0]     bit_q, bit_d;
  logic [4:0]     byte_q, byte_d;
  logic [1:0]     frame_q, frame_d;
  logic [127:0]   data_q, data_d;
  logic [2:0]     bright_q, bright_d;
  logic           on_q, on_d;
  logic           stb_q, stb_d, sclk_q, sclk_d, dio_q, dio_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [7:0]     cur_byte_s;

  // Byte on the wire for a given frame/index; F1 index 0 is the address command.
  function automatic logic [7:0] frame_byte(input logic [1:0] frame, input logic [4:0] idx,
                                            input logic [127:0] data, input logic [2:0] lvl,
                                            input logic on);
    logic [3:0] slot;
    logic [7:0] b;
    slot = 4'(idx - 5'd1);
    case (frame)
      2'd0:    b = 8'h40;
      2'd1:    b = (idx == 5'd0) ? 8'hC0 : data[{slot, 3'b000} +: 8];
      2'd2:    b = {4'b1000, on, lvl};
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  // Sequencer next state; line levels are derived from the next state so they change with it.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    frame_d  = frame_q;
    data_d   = data_q;
    bright_d = bright_q;
    on_d     = on_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = BIT_LO;
          div_d    = 16'd0;
          bit_d    = 3'd0;
          byte_d   = 5'd0;
          frame_d  = 2'd0;
          data_d   = disp_data;
          bright_d = bright;
          on_d     = disp_on;
        end else begin
          state_d = IDLE;
        end
      end
      BIT_LO: begin
        if ({1'b0, div_q} == PHASE_LAST) begin
          div_d   = 16'd0;
          state_d = BIT_HI;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      BIT_HI: begin
        if ({1'b0, div_q} == PHASE_LAST) begin
          div_d = 16'd0;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            state_d = BIT_LO;
          end else if (frame_q == 2'd1 && byte_q != 5'd16) begin
            bit_d   = 3'd0;
            byte_d  = byte_q + 5'd1;
            state_d = BIT_LO;
          end else begin
            bit_d   = 3'd0;
            state_d = GAP;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      GAP: begin
        if ({1'b0, div_q} == GAP_LAST) begin
          div_d = 16'd0;
          if (frame_q == 2'd2) begin
            frame_d = 2'd0;
            state_d = IDLE;
          end else begin
            frame_d = frame_q + 2'd1;
            byte_d  = 5'd0;
            state_d = BIT_LO;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    cur_byte_s = frame_byte(frame_d, byte_d, data_d, bright_d, on_d);
    stb_d  = (state_d == IDLE) || (state_d == GAP);
    sclk_d = (state_d != BIT_LO);
    dio_d  = (state_d == BIT_LO || state_d == BIT_HI) ? cur_byte_s[bit_d] : 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q == GAP) && (state_d == IDLE);
  end

  // State, counters, shadow settings and registered line outputs.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= 16'd0;
      bit_q    <= 3'd0;
      byte_q   <= 5'd0;
      frame_q  <= 2'd0;
      data_q   <= 128'd0;
      bright_q <= 3'd0;
      on_q     <= 1'b0;
      stb_q    <= 1'b1;
      sclk_q   <= 1'b1;
      dio_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      frame_q  <= frame_d;
      data_q   <= data_d;
      bright_q <= bright_d;
      on_q     <= on_d;
      stb_q    <= stb_d;
      sclk_q   <= sclk_d;
      dio_q    <= dio_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign stb  = stb_q;
  assign sclk = sclk_q;
  assign dio  = dio_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
